pulse_synchro_arbiter: RTL
==========================

Name: pulse_synchro_arbiter

Overview:
- Shares one pulse_synchro CDC channel among NB_REQ requesters in the source clock domain.
- Latches single-cycle event pulses per requester and picks one pending event round-robin.
- Emits one pulse plus a quasi-static requester ID towards the synchronizer.
- Holds the channel until the destination acknowledges through the return synchronizer, then enforces a minimum gap before the next send.

Parameters:
- NB_REQ, 4, number of requesters (2..16).
- ID_W, 2, width of requester ID; must be at least log2(NB_REQ).
- MIN_GAP, 2, idle cycles enforced after ack before the next send (0 allowed).
- TIMEOUT, 64, ack wait limit in cycles; used only with the optional feature.

Ports:
- aclk  in  1  clock.
- arst  in  1  asynchronous reset, active-high.
- req_i  in  NB_REQ  per-requester event pulses, one cycle each.
- grant_o  out  NB_REQ  one-hot, high for the single SEND cycle of the served requester.
- pending_o  out  NB_REQ  latched, not-yet-sent events.
- ovf_o  out  NB_REQ  one-cycle pulse when an event hits an already-pending slot.
- sync_pulse_o  out  1  one-cycle pulse to the pulse_synchro input.
- sync_id_o  out  ID_W  ID of the served requester; stable from SEND through end of WAIT_ACK.
- sync_ack_i  in  1  ack pulse returned from the destination domain (already synchronized).
- busy_o  out  1  high whenever state is not IDLE.
- timeout_o  out  1  one-cycle pulse on ack timeout.

Behaviour:
- Reset (async, any time, including mid-transfer):
  - state IDLE; pending, ptr, gap counter and timeout counter cleared.
  - All outputs 0. In-flight and pending events are discarded; no pulse is emitted after reset release until a new req_i.
- All outputs are registered.
- Pending:
  - req_i[k]=1 at cycle t sets pending[k], visible at t+1.
  - req_i[k]=1 while pending[k]=1 and not being cleared: pending stays 1, ovf_o[k]=1 at t+1.
  - req_i[k]=1 in the same cycle pending[k] is cleared by SEND: pending[k] stays 1, no ovf.
- FSM states: IDLE, SEND, WAIT_ACK, GAP.
- IDLE:
  - If pending is non-zero, select the first set bit scanning upward from ptr, wrapping NB_REQ-1 to 0.
  - Latch the selected ID into sync_id_o and go to SEND.
- SEND (exactly 1 cycle):
  - sync_pulse_o=1 and grant_o[id]=1.
  - Clear pending[id]; ptr <= (id+1) mod NB_REQ.
  - Next state WAIT_ACK.
- Latency: an event on an idle arbiter with nothing else pending produces sync_pulse_o exactly 2 cycles after req_i.
- WAIT_ACK:
  - sync_id_o held.
  - sync_ack_i=1 -> GAP with counter=MIN_GAP; if MIN_GAP=0, go directly to IDLE.
  - sync_ack_i in IDLE, SEND or GAP is ignored.
- GAP: counter decrements each cycle; reaching 0 -> IDLE. The next SEND occurs at earliest 1 cycle after re-entering IDLE.
- sync_id_o: holds its last value in GAP and IDLE until the next selection.
- Fairness: with all requesters continuously pending, grants rotate 0,1,...,NB_REQ-1,0...

Optional Feature:
- Macro: PULSE_SYNCHRO_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_ACK, cleared on entry.
  - If TIMEOUT cycles elapse without ack: timeout_o pulses 1 cycle and the FSM goes to GAP, treated as if acked.
  - A late ack arriving afterwards is ignored unless the FSM is again in WAIT_ACK.
- Undefined: WAIT_ACK waits indefinitely; timeout_o tied 0; no counter logic.

Test Plan:
- Reset then idle 20 cycles -> all outputs 0, busy_o=0.
- req_i=4'b0100 for 1 cycle, ack 10 cycles after pulse, MIN_GAP=2:
  - sync_pulse_o high 2 cycles after req, sync_id_o=2, grant_o=4'b0100.
  - sync_id_o stable until ack; busy_o low 3 cycles after ack.
- req_i=4'b1111 in one cycle, ack each pulse after 5 cycles -> four sends with IDs 0,1,2,3; pending_o drains to 0; no ovf.
- req_i[1] pulsed twice while WAIT_ACK for ID 1 is still pending behind ID 0:
  - Second pulse gives ovf_o[1] for 1 cycle.
  - Only one send with ID 1.
- Assert arst during WAIT_ACK with pending=4'b1010 -> outputs 0 immediately; after release, no sync_pulse_o without new req_i.
- With PULSE_SYNCHRO_ARB_TIMEOUT_EN, TIMEOUT=64, no ack:
  - timeout_o pulses 64 cycles after SEND.
  - The next pending request is sent after MIN_GAP.
  - Without the macro, busy_o stays 1 indefinitely.

Source files
------------

// File: rtl/pulse_synchro_arbiter.sv
// pulse_synchro_arbiter
// Shares one pulse_synchro CDC channel among NB_REQ source-domain requesters.
// Single-cycle event pulses are latched per requester, one pending event is
// picked round-robin, and a pulse plus a quasi-static requester ID is sent to
// the synchronizer. The channel is held until the destination ack returns,
// then MIN_GAP idle cycles are enforced before the next send.
//
// Optional feature: define PULSE_SYNCHRO_ARB_TIMEOUT_EN to abort an ack wait
// after TIMEOUT cycles (timeout_o pulses, the FSM proceeds as if acked).
// Without the macro the ack wait is unbounded and timeout_o is tied to 0.

module pulse_synchro_arbiter #(
  parameter int NB_REQ  = 4,
  parameter int ID_W    = 2,
  parameter int MIN_GAP = 2,
  parameter int TIMEOUT = 64
) (
  input  logic              aclk,
  input  logic              arst,
  input  logic [NB_REQ-1:0] req_i,
  output logic [NB_REQ-1:0] grant_o,
  output logic [NB_REQ-1:0] pending_o,
  output logic [NB_REQ-1:0] ovf_o,
  output logic              sync_pulse_o,
  output logic [ID_W-1:0]   sync_id_o,
  input  logic              sync_ack_i,
  output logic              busy_o,
  output logic              timeout_o
);

  localparam int PTR_W = $clog2(NB_REQ);
  localparam int GAP_W = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_ACK,
    GAP
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] cur_idx;
  logic [GAP_W-1:0] gap_cnt;
  logic             sel_valid;
  logic [PTR_W-1:0] sel_idx;
  logic [PTR_W-1:0] ptr_next;

`ifdef PULSE_SYNCHRO_ARB_TIMEOUT_EN
  // The counter starts at 0 on the first WAIT_ACK cycle; firing at TIMEOUT-2
  // puts the timeout_o pulse exactly TIMEOUT cycles after the SEND cycle.
  localparam int TO_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int TO_LAST = (TIMEOUT >= 2) ? TIMEOUT - 2 : 0;
  logic [TO_W-1:0] to_cnt;
`else
  assign timeout_o = 1'b0;
`endif

  // Round-robin pick: first pending bit scanning upward from ptr with wrap.
  always_comb begin
    logic [PTR_W:0] pos;
    sel_valid = 1'b0;
    sel_idx   = '0;
    pos       = '0;
    for (int i = 0; i < NB_REQ; i++) begin
      pos = {1'b0, ptr} + (PTR_W + 1)'(i);
      if (pos >= (PTR_W + 1)'(NB_REQ)) begin
        pos = pos - (PTR_W + 1)'(NB_REQ);
      end
      if (!sel_valid && pending_o[pos[PTR_W-1:0]]) begin
        sel_valid = 1'b1;
        sel_idx   = pos[PTR_W-1:0];
      end
    end
  end

  // Pointer moves to the requester just after the one being served.
  always_comb begin
    ptr_next = cur_idx + PTR_W'(1);
    if (cur_idx == PTR_W'(NB_REQ - 1)) begin
      ptr_next = '0;
    end
  end

  // Event latches: grant_o is the one-hot clear mask during SEND, so a new
  // event on the slot being served re-arms it without an overflow.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      pending_o <= '0;
      ovf_o     <= '0;
    end else begin
      pending_o <= (pending_o & ~grant_o) | req_i;
      ovf_o     <= req_i & pending_o & ~grant_o;
    end
  end

  // Channel FSM with registered pulse, grant, ID, busy and timeout outputs.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state        <= IDLE;
      ptr          <= '0;
      cur_idx      <= '0;
      gap_cnt      <= '0;
      grant_o      <= '0;
      sync_pulse_o <= 1'b0;
      sync_id_o    <= '0;
      busy_o       <= 1'b0;
`ifdef PULSE_SYNCHRO_ARB_TIMEOUT_EN
      to_cnt       <= '0;
      timeout_o    <= 1'b0;
`endif
    end else begin
      grant_o      <= '0;
      sync_pulse_o <= 1'b0;
`ifdef PULSE_SYNCHRO_ARB_TIMEOUT_EN
      timeout_o    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (sel_valid) begin
            state        <= SEND;
            cur_idx      <= sel_idx;
            sync_id_o    <= ID_W'(sel_idx);
            sync_pulse_o <= 1'b1;
            grant_o      <= NB_REQ'(1) << sel_idx;
            busy_o       <= 1'b1;
          end else begin
            busy_o <= 1'b0;
          end
        end

        SEND: begin
          state  <= WAIT_ACK;
          ptr    <= ptr_next;
          busy_o <= 1'b1;
`ifdef PULSE_SYNCHRO_ARB_TIMEOUT_EN
          to_cnt <= '0;
`endif
        end

        WAIT_ACK: begin
          busy_o <= 1'b1;
`ifdef PULSE_SYNCHRO_ARB_TIMEOUT_EN
          if (sync_ack_i || (to_cnt == TO_W'(TO_LAST))) begin
            timeout_o <= ~sync_ack_i;
`else
          if (sync_ack_i) begin
`endif
            if (MIN_GAP == 0) begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end else begin
              state   <= GAP;
              gap_cnt <= GAP_W'(MIN_GAP);
            end
          end
`ifdef PULSE_SYNCHRO_ARB_TIMEOUT_EN
          else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
`endif
        end

        GAP: begin
          gap_cnt <= gap_cnt - GAP_W'(1);
          if (gap_cnt <= GAP_W'(1)) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            busy_o <= 1'b1;
          end
        end

        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
